tdc_decoder: RTL and testbench

- Digital-side consumer of the analog top's 64-bit sampled TDC snapshot.
- Turns each sampled delay-line thermometer word into three results: a rising-edge phase code, a DCO period estimate in TDC units (IIR-averaged), and an edge-miss error count.
- Sits between the analog top's sampled_tdc output and the phase detector / digital loop filter that produce dlf_out, in the ref_clk domain.

---
 rtl/tdc_decoder.sv | 171 +++++++++++++++++
 tb/tb_tdc_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tdc_decoder.sv
// tdc_decoder: decodes the sampled 64-bit TDC delay-line snapshot into a
// rising-edge phase code, an IIR-averaged DCO period estimate and an
// edge-miss error count.  Three-stage pipeline in the ref_clk domain:
// S1 capture/invert/filter, S2 edge search, S3 output and IIR update.
// Optional feature macro: TDC_BUBBLE_FILT_EN (3-tap majority bubble filter in S1).
//
// Handshake: tdc_vld_in qualifies sampled_tdc for one cycle (no back-pressure,
// a sample may arrive every cycle); tdc_valid is a one-cycle pulse exactly
// three cycles later, and tdc_edge_miss is only ever high together with it.
module tdc_decoder #(
  parameter int TDC_W    = 64,
  parameter int PER_FRAC = 4,
  parameter int ERR_W    = 8,
  localparam int POS_W   = $clog2(TDC_W),
  localparam int PER_W   = POS_W + 1,
  localparam int ACC_W   = PER_W + PER_FRAC
) (
  input  logic             ref_clk,
  input  logic             rst_n,
  input  logic [TDC_W-1:0] sampled_tdc,
  input  logic             tdc_vld_in,
  input  logic             csr_tdc_en,
  input  logic             csr_tdc_inv_pol,
  input  logic [2:0]       csr_tdc_avg_shift,
  input  logic             csr_tdc_err_clr,
  output logic             tdc_valid,
  output logic [POS_W-1:0] tdc_phase,
  output logic [PER_W-1:0] tdc_period,
  output logic             tdc_edge_miss,
  output logic [ERR_W-1:0] tdc_err_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, TRACK = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;

  logic [TDC_W-1:0]   s1_raw, s1_filt, s1_word_q;
  logic               s1_vld_q;
  logic [POS_W-1:0]   rise_d, fall_d, s2_rise_q, s2_fall_q;
  logic               rise_found_d, fall_found_d, s2_rf_q, s2_ff_q, s2_vld_q;

  logic               tdc_valid_q, tdc_edge_miss_q;
  logic [POS_W-1:0]   tdc_phase_q;
  logic [ERR_W-1:0]   err_cnt_q;

  logic               accept, s3_go, upd_per, miss;
  logic [PER_W-1:0]   period_raw;
  logic [ACC_W-1:0]   target, acc_trk;
  logic signed [ACC_W:0] diff, shifted, sum;

  // Samples are only taken while enabled and out of IDLE.
  assign accept = tdc_vld_in && csr_tdc_en && (state_q != IDLE);
  assign s1_raw = csr_tdc_inv_pol ? ~sampled_tdc : sampled_tdc;

`ifdef TDC_BUBBLE_FILT_EN
  // Majority-of-three smoothing removes single-bit bubbles; end bits pass through.
  always_comb begin
    s1_filt = s1_raw;
    for (int i = 1; i < TDC_W - 1; i++) begin
      s1_filt[i] = (s1_raw[i-1] & s1_raw[i]) | (s1_raw[i-1] & s1_raw[i+1]) |
                   (s1_raw[i] & s1_raw[i+1]);
    end
  end
`else
  assign s1_filt = s1_raw;
`endif

  // Edge search: first 0->1 transition, then first 1->0 transition above it.
  always_comb begin
    rise_found_d = 1'b0;
    fall_found_d = 1'b0;
    rise_d       = '0;
    fall_d       = '0;
    for (int i = 1; i < TDC_W; i++) begin
      if (!rise_found_d && !s1_word_q[i-1] && s1_word_q[i]) begin
        rise_found_d = 1'b1;
        rise_d       = POS_W'(i);
      end else if (rise_found_d && !fall_found_d && s1_word_q[i-1] && !s1_word_q[i]) begin
        fall_found_d = 1'b1;
        fall_d       = POS_W'(i);
      end
    end
  end

  // S3 qualifiers: a disable kills anything still in flight.
  assign s3_go   = s2_vld_q && csr_tdc_en;
  assign upd_per = s3_go && s2_rf_q && s2_ff_q;
  assign miss    = s3_go && !s2_rf_q;

  // Period IIR: signed difference, arithmetic shift, clamp at zero.
  assign period_raw = {s2_fall_q - s2_rise_q, 1'b0};
  assign target     = {period_raw, {PER_FRAC{1'b0}}};
  assign diff       = $signed({1'b0, target}) - $signed({1'b0, acc_q});
  assign shifted    = diff >>> csr_tdc_avg_shift;
  assign sum        = $signed({1'b0, acc_q}) + shifted;
  assign acc_trk    = sum[ACC_W] ? '0 : sum[ACC_W-1:0];

  // Next-state and accumulator update; disabling always returns to IDLE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE:  if (csr_tdc_en) state_d = INIT;
      INIT:  if (upd_per) begin
               acc_d   = target;
               state_d = TRACK;
             end
      TRACK: if (upd_per) acc_d = acc_trk;
      default: state_d = IDLE;
    endcase
    if (!csr_tdc_en) state_d = IDLE;
  end

  // State register and accumulator.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  // S1/S2 pipeline registers; valid bits flush whenever the decoder is disabled.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_word_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_rise_q <= '0;
      s2_fall_q <= '0;
      s2_rf_q   <= 1'b0;
      s2_ff_q   <= 1'b0;
    end else begin
      s1_vld_q  <= accept;
      s1_word_q <= s1_filt;
      s2_vld_q  <= s1_vld_q && csr_tdc_en;
      s2_rise_q <= rise_d;
      s2_fall_q <= fall_d;
      s2_rf_q   <= rise_found_d;
      s2_ff_q   <= fall_found_d;
    end
  end

  // S3 output registers: phase holds on a miss, error counter saturates, clear wins.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      tdc_valid_q     <= 1'b0;
      tdc_edge_miss_q <= 1'b0;
      tdc_phase_q     <= '0;
      err_cnt_q       <= '0;
    end else begin
      tdc_valid_q     <= s3_go;
      tdc_edge_miss_q <= miss;
      if (s3_go && s2_rf_q) tdc_phase_q <= s2_rise_q;
      if (csr_tdc_err_clr)             err_cnt_q <= '0;
      else if (miss && !(&err_cnt_q))  err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign tdc_valid     = tdc_valid_q;
  assign tdc_edge_miss = tdc_edge_miss_q;
  assign tdc_phase     = tdc_phase_q;
  assign tdc_period    = acc_q[ACC_W-1:PER_FRAC];
  assign tdc_err_cnt   = err_cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_tdc_decoder.sv
// Directed-vector bench for tdc_decoder.  Stimulus pushes hand-computed
// expectations {issue cycle, miss, phase, period, err_cnt} into exp_q; a
// negedge monitor pops one entry for every tdc_valid pulse and compares.
module tb_tdc_decoder;

  logic        ref_clk = 1'b0;
  logic        rst_n;
  logic [63:0] sampled_tdc;
  logic        tdc_vld_in;
  logic        csr_tdc_en;
  logic        csr_tdc_inv_pol;
  logic [2:0]  csr_tdc_avg_shift;
  logic        csr_tdc_err_clr;
  logic        tdc_valid;
  logic [5:0]  tdc_phase;
  logic [6:0]  tdc_period;
  logic        tdc_edge_miss;
  logic [7:0]  tdc_err_cnt;
  logic [1:0]  dbg_state;

  logic [15:0] cyc = '0;
  logic [37:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [5:0]  bub_ph;
  logic [6:0]  bub_per;

  tdc_decoder dut (
    .ref_clk           (ref_clk),
    .rst_n             (rst_n),
    .sampled_tdc       (sampled_tdc),
    .tdc_vld_in        (tdc_vld_in),
    .csr_tdc_en        (csr_tdc_en),
    .csr_tdc_inv_pol   (csr_tdc_inv_pol),
    .csr_tdc_avg_shift (csr_tdc_avg_shift),
    .csr_tdc_err_clr   (csr_tdc_err_clr),
    .tdc_valid         (tdc_valid),
    .tdc_phase         (tdc_phase),
    .tdc_period        (tdc_period),
    .tdc_edge_miss     (tdc_edge_miss),
    .tdc_err_cnt       (tdc_err_cnt),
    .dbg_state         (dbg_state)
  );

  // Clock and cycle counter.
  always #5 ref_clk = ~ref_clk;
  always @(posedge ref_clk) cyc <= cyc + 16'd1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Thermometer word with ones in bits [r, f-1], zeros elsewhere.
  function automatic logic [63:0] mk(input int r, input int f);
    logic [63:0] w = '0;
    for (int i = r; i < f; i++) w[i] = 1'b1;
    return w;
  endfunction

  // Driver: one-cycle sample plus its expected result.  Called at posedge+1.
  task automatic send(input logic [63:0] w, input logic [5:0] ph, input logic [6:0] per,
                      input logic ms, input logic [7:0] err);
    sampled_tdc = w;
    tdc_vld_in  = 1'b1;
    exp_q.push_back({cyc, ms, ph, per, err});
    @(posedge ref_clk); #1;
    tdc_vld_in  = 1'b0;
    sampled_tdc = '0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(posedge ref_clk);
      t++;
    end
    #1;
    chk("drain_timeout", exp_q.size(), 0);
    @(posedge ref_clk); #1;
  endtask

  // Monitor / scoreboard.
  always @(negedge ref_clk) begin
    logic [37:0] e;
    logic [15:0] lat;
    if (tdc_edge_miss && !tdc_valid) begin
      n_fail++;
      $display("FAIL miss_without_valid: got 1 expected 0 (t=%0t)", $time);
    end
    if (tdc_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: got phase %0d, nothing expected (t=%0t)", tdc_phase, $time);
      end else begin
        e   = exp_q.pop_front();
        lat = cyc - e[37:22];
        chk("latency",   int'(lat),           3);
        chk("edge_miss", int'(tdc_edge_miss), int'(e[21]));
        chk("phase",     int'(tdc_phase),     int'(e[20:15]));
        chk("period",    int'(tdc_period),    int'(e[14:8]));
        chk("err_cnt",   int'(tdc_err_cnt),   int'(e[7:0]));
      end
    end
  end

  initial begin
    rst_n = 1'b0; sampled_tdc = '0; tdc_vld_in = 1'b0; csr_tdc_en = 1'b0;
    csr_tdc_inv_pol = 1'b0; csr_tdc_avg_shift = 3'd2; csr_tdc_err_clr = 1'b0;
`ifdef TDC_BUBBLE_FILT_EN
    bub_ph = 6'd20; bub_per = 7'd61;
`else
    bub_ph = 6'd10; bub_per = 7'd45;
`endif
    repeat (3) @(posedge ref_clk);
    #1 rst_n = 1'b1;
    @(posedge ref_clk); #1;
    chk("rst_valid",  int'(tdc_valid),     0);
    chk("rst_phase",  int'(tdc_phase),     0);
    chk("rst_period", int'(tdc_period),    0);
    chk("rst_miss",   int'(tdc_edge_miss), 0);
    chk("rst_err",    int'(tdc_err_cnt),   0);
    chk("rst_state",  int'(dbg_state),     0);

    csr_tdc_en = 1'b1;
    repeat (3) @(posedge ref_clk); #1;

    // Basic decode (INIT load) and IIR tracking.
    send(mk(20, 52), 6'd20, 7'd64, 1'b0, 8'd0);
    drain();
    send(mk(20, 50), 6'd20, 7'd63, 1'b0, 8'd0);   // k=2: 1024-16=1008
    drain();
    csr_tdc_avg_shift = 3'd0;
    send(mk(20, 50), 6'd20, 7'd60, 1'b0, 8'd0);   // k=0: 960
    drain();
    csr_tdc_avg_shift = 3'd1;
    send(mk(30, 63), 6'd30, 7'd63, 1'b0, 8'd0);   // fall at 63: 960+48=1008
    send(64'h8000_0000_0000_0000, 6'd63, 7'd63, 1'b0, 8'd0); // rise only at 63
    drain();
    csr_tdc_avg_shift = 3'd3;
    send(mk(1, 3), 6'd1, 7'd55, 1'b0, 8'd0);      // 1008-118=890
    drain();

    // Back-to-back at full rate, k=0.
    csr_tdc_avg_shift = 3'd0;
    send(mk(5, 9),   6'd5,  7'd8,  1'b0, 8'd0);
    send(mk(12, 44), 6'd12, 7'd64, 1'b0, 8'd0);
    send(mk(40, 42), 6'd40, 7'd4,  1'b0, 8'd0);
    drain();

    // Inverted polarity.
    csr_tdc_inv_pol = 1'b1;
    send(~mk(20, 52), 6'd20, 7'd64, 1'b0, 8'd0);
    drain();
    csr_tdc_inv_pol = 1'b0;

    // Disable one cycle after the sample: nothing may come out.
    sampled_tdc = mk(20, 50);
    tdc_vld_in  = 1'b1;
    @(posedge ref_clk); #1;
    tdc_vld_in  = 1'b0;
    sampled_tdc = '0;
    csr_tdc_en  = 1'b0;
    @(posedge ref_clk); #1;
    chk("flush_state_idle", int'(dbg_state), 0);
    repeat (4) @(posedge ref_clk); #1;
    csr_tdc_en = 1'b1;
    repeat (3) @(posedge ref_clk); #1;
    chk("reenable_state_init", int'(dbg_state), 1);
    csr_tdc_avg_shift = 3'd2;
    send(mk(20, 50), 6'd20, 7'd60, 1'b0, 8'd0);   // INIT reload: 960
    drain();

    // Bubble at bit 10.
    send(mk(20, 52) | 64'h400, bub_ph, bub_per, 1'b0, 8'd0);
    drain();

    // Misses: saturation, then clear coincident with a miss, then count again.
    for (int i = 0; i < 300; i++)
      send('0, bub_ph, bub_per, 1'b1, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
    drain();
    send('1, bub_ph, bub_per, 1'b1, 8'd0);
    @(posedge ref_clk); #1;
    csr_tdc_err_clr = 1'b1;
    @(posedge ref_clk); #1;
    csr_tdc_err_clr = 1'b0;
    drain();
    send('1, bub_ph, bub_per, 1'b1, 8'd1);
    drain();

    // Asynchronous reset with a sample in flight.
    sampled_tdc = mk(20, 52);
    tdc_vld_in  = 1'b1;
    @(posedge ref_clk); #1;
    tdc_vld_in  = 1'b0;
    sampled_tdc = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",  int'(tdc_valid),   0);
    chk("mid_rst_phase",  int'(tdc_phase),   0);
    chk("mid_rst_period", int'(tdc_period),  0);
    chk("mid_rst_err",    int'(tdc_err_cnt), 0);
    chk("mid_rst_state",  int'(dbg_state),   0);
    @(posedge ref_clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge ref_clk); #1;
    chk("post_rst_state_init", int'(dbg_state), 1);
    send(mk(20, 52), 6'd20, 7'd64, 1'b0, 8'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
